task_write_pattern: RTL and testbench
=====================================

Name: task_write_pattern

Overview:
- Self-test writer that fills raw microSD blocks with a deterministic pseudo-random byte stream through the SD SPI controller's multi-block write interface.
- It drives its own reset of the SPI controller, then streams BYTES_TO_WRITE bytes starting at block FIRST_RAW_BLOCK, then closes the transfer.
- The read/compare task later checks the same blocks against the same stream.
- It sits beside the compare task in the Nexys4DDR microSD example top level and owns the SPI controller while it runs.

Parameters:
- BYTES_TO_WRITE, 1024: total bytes written; must be a multiple of 512 and at least 512.
- FIRST_RAW_BLOCK, 50: first SD block address written.
- SEED, 16'hACE1: LFSR seed; must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rst_spi  out  1  reset request to the SD SPI controller
- w_multi_block  out  1  held high for the whole multi-block write
- w_byte  out  1  one-cycle strobe: controller accepts data_out
- block_addr  out  32  constant FIRST_RAW_BLOCK
- data_out  out  8  byte being written
- spi_busy  in  1  controller busy
- spi_err  in  1  controller error (R1/data-response failure)
- bytes_written  out  32  count of accepted bytes
- checksum  out  16  running byte sum (see Optional Feature)
- end_signal  out  1  high in END_STATE
- error  out  1  high in ERROR

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high; state and all registers clear immediately on assertion.
- Reset values:
  - State is IDLE.
  - All outputs are 0 except block_addr, which is always FIRST_RAW_BLOCK.
  - LFSR = SEED, bytes_written = 0, checksum = 0.
- Outputs are combinational from the state, unless stated otherwise.
- spi_err high in any state except IDLE forces ERROR on the next edge. This has priority over all other transitions.
- State machine:
  - IDLE: clear the counter and reload the LFSR. Go to RST_SPI.
  - RST_SPI: rst_spi=1 for exactly one cycle. Go to WAIT_READY.
  - WAIT_READY: wait for spi_busy=0, then go to START.
  - START: w_multi_block=1. Go to WAIT_START.
  - WAIT_START: w_multi_block=1. Ignore spi_busy in the first cycle, since the controller needs one cycle to raise it. From the next cycle on, spi_busy=0 moves to WRITE_BYTE.
  - WRITE_BYTE: w_multi_block=1, w_byte=1, data_out=LFSR[7:0].
    - On this edge, bytes_written increments.
    - The LFSR advances once: new = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
    - Go to WAIT_BYTE.
  - WAIT_BYTE: w_multi_block=1; data_out is held. Ignore spi_busy in the first cycle. After that, spi_busy=0 leads to:
    - WRITE_BYTE if bytes_written < BYTES_TO_WRITE;
    - otherwise STOP.
  - STOP: w_multi_block=0, which makes the controller send the stop token. Go to WAIT_STOP.
  - WAIT_STOP: ignore the first cycle. spi_busy=0 then moves to END_STATE.
  - END_STATE and ERROR: terminal. Only rst leaves them. end_signal or error is held high.
- Block boundaries (every 512 bytes) are handled inside the controller. The task streams bytes continuously.
- The counter is 32 bits. Parameter limits guarantee no wrap.
- Reset during a transfer: the task returns to IDLE and re-issues rst_spi. Any partial SD write is abandoned; the card is recovered by the controller reset.

Optional Feature:
- Macro: TASK_WRITE_CHECKSUM_EN.
- When defined, checksum accumulates data_out (modulo 2^16) on each WRITE_BYTE edge, is cleared in IDLE, and is frozen in END_STATE and ERROR.
- When undefined, checksum is tied to 16'h0000 and no adder is built.

Decomposition:
- Package task_write_pkg holds:
  - the state enum (4 bits);
  - the LFSR tap constants;
  - BLOCK_BYTES=512;
  - the first-cycle-ignore width constant.
- Sub-module pattern_lfsr, shared with the compare task so both sides generate the same stream. Its ports: clk, rst, load, advance, seed[15:0], q[15:0].

Test Plan:
- Nominal run, BYTES_TO_WRITE=512, busy model of 3 cycles per byte:
  - exactly one rst_spi pulse;
  - 512 w_byte strobes;
  - data_out of byte0=8'hE1, byte1=8'hC3;
  - end_signal=1 and bytes_written=512.
- BYTES_TO_WRITE=1024: w_multi_block stays high continuously across the block-512 boundary and 1024 strobes are counted. STOP occurs only after the 1024th byte's busy clears.
- spi_err pulsed during byte 100: error=1 on the next cycle, no further w_byte strobes, w_multi_block=0.
- rst asserted mid-byte 37 with no clock edge: all outputs read 0 immediately. After release, a new rst_spi pulse is issued and data_out restarts at 8'hE1.
- spi_busy held high for 50 cycles after START: no w_byte until it drops, then the first strobe comes the cycle after WAIT_START exits.
- TASK_WRITE_CHECKSUM_EN defined, first two bytes: checksum = 16'h01A4 (0xE1+0xC3). With the macro undefined, checksum is 0 throughout.

Source files
------------

// File: rtl/task_write_pkg.sv
// Shared types and constants for the raw-block pattern writer and its LFSR.
package task_write_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        RST_SPI    = 4'd1,
        WAIT_READY = 4'd2,
        START      = 4'd3,
        WAIT_START = 4'd4,
        WRITE_BYTE = 4'd5,
        WAIT_BYTE  = 4'd6,
        STOP       = 4'd7,
        WAIT_STOP  = 4'd8,
        END_STATE  = 4'd9,
        ERROR      = 4'd10
    } state_t;

    localparam int BLOCK_BYTES = 512;

    // Feedback taps of the 16-bit Fibonacci LFSR shared by the write and compare tasks.
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    // Width of the counter that masks spi_busy right after entering a wait state.
    localparam int IGNORE_W = 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B] ^ l[LFSR_TAP_C] ^ l[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// Byte-pattern LFSR shared by the write and compare tasks so both see the same stream.
module pattern_lfsr
    import task_write_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_SEED;
        end else if (load) begin
            q <= seed;
        end else if (advance) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/task_write_pattern.sv
// Self-test writer: streams the LFSR pattern into raw SD blocks via the controller's multi-block write.
// Define TASK_WRITE_CHECKSUM_EN to build the running byte-sum on checksum.
module task_write_pattern
    import task_write_pkg::*;
#(
    parameter int          BYTES_TO_WRITE  = 1024,
    parameter int          FIRST_RAW_BLOCK = 50,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rst_spi,
    output logic        w_multi_block,
    output logic        w_byte,
    output logic [31:0] block_addr,
    output logic [7:0]  data_out,
    input  logic        spi_busy,
    input  logic        spi_err,
    output logic [31:0] bytes_written,
    output logic [15:0] checksum,
    output logic        end_signal,
    output logic        error
);

    localparam logic [31:0] TOTAL_BYTES = 32'(BYTES_TO_WRITE);

    state_t              state;
    state_t              state_next;
    logic [IGNORE_W-1:0] ignore_cnt;
    logic                ignore_done;
    logic [15:0]         lfsr_q;
    logic [7:0]          data_q;
    logic [31:0]         count_q;

    assign ignore_done   = (ignore_cnt == '0);
    assign block_addr    = 32'(FIRST_RAW_BLOCK);
    assign bytes_written = count_q;

    pattern_lfsr #(.RESET_SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (state == IDLE),
        .advance (state == WRITE_BYTE),
        .seed    (SEED),
        .q       (lfsr_q)
    );

    // The controller raises busy one cycle late, so every fresh state entry masks it briefly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ignore_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                ignore_cnt <= '1;
            end else if (!ignore_done) begin
                ignore_cnt <= ignore_cnt - IGNORE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            data_q  <= '0;
        end else if (state == IDLE) begin
            count_q <= '0;
        end else if (state == WRITE_BYTE) begin
            count_q <= count_q + 32'd1;
            data_q  <= lfsr_q[7:0];
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:       state_next = RST_SPI;
            RST_SPI:    state_next = WAIT_READY;
            WAIT_READY: if (!spi_busy) state_next = START;
            START:      state_next = WAIT_START;
            WAIT_START: if (ignore_done && !spi_busy) state_next = WRITE_BYTE;
            WRITE_BYTE: state_next = WAIT_BYTE;
            WAIT_BYTE:  if (ignore_done && !spi_busy)
                            state_next = (count_q < TOTAL_BYTES) ? WRITE_BYTE : STOP;
            STOP:       state_next = WAIT_STOP;
            WAIT_STOP:  if (ignore_done && !spi_busy) state_next = END_STATE;
            END_STATE,
            ERROR:      state_next = state;
            default:    state_next = IDLE;
        endcase
        // A controller error aborts any active phase; the terminal states stay put until rst.
        if (spi_err && !(state inside {IDLE, END_STATE, ERROR})) begin
            state_next = ERROR;
        end
    end

    always_comb begin
        rst_spi       = 1'b0;
        w_multi_block = 1'b0;
        w_byte        = 1'b0;
        data_out      = '0;
        end_signal    = 1'b0;
        error         = 1'b0;
        unique case (state)
            RST_SPI:           rst_spi = 1'b1;
            START, WAIT_START: w_multi_block = 1'b1;
            WRITE_BYTE: begin
                w_multi_block = 1'b1;
                w_byte        = 1'b1;
                data_out      = lfsr_q[7:0];
            end
            WAIT_BYTE: begin
                w_multi_block = 1'b1;
                data_out      = data_q;
            end
            END_STATE:         end_signal = 1'b1;
            ERROR:             error = 1'b1;
            default:           ;
        endcase
    end

`ifdef TASK_WRITE_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state == IDLE) begin
            sum_q <= '0;
        end else if (state == WRITE_BYTE) begin
            sum_q <= sum_q + {8'h00, lfsr_q[7:0]};
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_task_write_pattern.sv
// Bench for task_write_pattern: scenario table plus a behavioural SPI-controller busy model.
module tb_task_write_pattern;

    localparam int          N_BYTES = 1024;
    localparam int          BLK     = 50;
    localparam logic [15:0] SEED_V  = 16'hACE1;
    localparam int          BUDGET  = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_spi;
    logic        w_multi_block;
    logic        w_byte;
    logic [31:0] block_addr;
    logic [7:0]  data_out;
    logic        spi_busy;
    logic        spi_err;
    logic [31:0] bytes_written;
    logic [15:0] checksum;
    logic        end_signal;
    logic        error;

    always #5 clk = ~clk;

    task_write_pattern #(
        .BYTES_TO_WRITE  (N_BYTES),
        .FIRST_RAW_BLOCK (BLK),
        .SEED            (SEED_V)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rst_spi       (rst_spi),
        .w_multi_block (w_multi_block),
        .w_byte        (w_byte),
        .block_addr    (block_addr),
        .data_out      (data_out),
        .spi_busy      (spi_busy),
        .spi_err       (spi_err),
        .bytes_written (bytes_written),
        .checksum      (checksum),
        .end_signal    (end_signal),
        .error         (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_bytes [N_BYTES];
    logic [7:0]  got_b0;
    logic [7:0]  got_b1;
    logic [15:0] got_csum2;

    typedef struct {
        int byte_busy;   // busy cycles per byte, -1 = random 0..4
        int start_busy;  // busy cycles after w_multi_block rises
        int err_at;      // pulse spi_err right after this many strobes, -1 = never
        int rst_at;      // async reset right after this many strobes, -1 = never
        int exp_strobes;
        bit exp_end;
        bit exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference stream straight from the recurrence: shift left, feed back bits 15^13^12^10.
    task automatic build_stream();
        int l;
        l = int'(SEED_V);
        for (int i = 0; i < N_BYTES; i++) begin
            exp_bytes[i] = 8'(l % 256);
            l = ((l * 2) % 65536) + (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rst_spi"}, 32'(rst_spi), 32'd0);
        check({tag, "_w_multi_block"}, 32'(w_multi_block), 32'd0);
        check({tag, "_w_byte"}, 32'(w_byte), 32'd0);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_bytes_written"}, bytes_written, 32'd0);
        check({tag, "_checksum"}, 32'(checksum), 32'd0);
        check({tag, "_end_signal"}, 32'(end_signal), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_block_addr"}, block_addr, 32'(BLK));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         strobes = 0;
        int         n_rst_spi = 0;
        int         busy_cnt = 0;
        int         rise_cyc = 0;
        int         err_state = 0;
        int         post = 0;
        int         exp_lat;
        bit         prev_wmb = 1'b0;
        bit         prev_busy = 1'b0;
        bit         first_after_rise = 1'b0;
        bit         hold_chk = 1'b0;
        bit         rst_done = 1'b0;
        bit         finished = 1'b0;
        logic [15:0] csum = '0;
        logic [7:0]  last_byte = '0;

        exp_lat = (v.start_busy + 1 > 3) ? v.start_busy + 1 : 3;
        @(negedge clk);
        rst = 1'b1;
        spi_busy = 1'b0;
        spi_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            if (err_state == 2) begin
                check("err_next_error", 32'(error), 32'd1);
                check("err_next_w_multi_block", 32'(w_multi_block), 32'd0);
                check("err_next_w_byte", 32'(w_byte), 32'd0);
                spi_err = 1'b0;
                err_state = 3;
            end
            if (rst_spi) n_rst_spi++;
            if (w_multi_block && !prev_wmb) begin
                rise_cyc = cyc;
                first_after_rise = 1'b1;
            end
            if (w_byte) begin
                if (first_after_rise) begin
                    check("start_latency", 32'(cyc - rise_cyc), 32'(exp_lat));
                    first_after_rise = 1'b0;
                end
                if (idx == 0 && strobes == 0) got_b0 = data_out;
                if (idx == 0 && strobes == 1) got_b1 = data_out;
                if (idx == 0 && strobes == 2) got_csum2 = checksum;
                if (strobes < N_BYTES) begin
                    check("data_out", 32'(data_out), 32'(exp_bytes[strobes]));
                    last_byte = exp_bytes[strobes];
                end else begin
                    check("strobe_beyond_total", 32'(strobes), 32'(N_BYTES - 1));
                end
                check("bytes_written_at_strobe", bytes_written, 32'(strobes));
                check("checksum_at_strobe", 32'(checksum), 32'(csum));
`ifdef TASK_WRITE_CHECKSUM_EN
                csum = csum + 16'(last_byte);
`endif
                strobes++;
                hold_chk = 1'b1;
            end else if (hold_chk) begin
                hold_chk = 1'b0;
                if (w_multi_block) check("data_hold", 32'(data_out), 32'(last_byte));
            end
            if (!w_multi_block && prev_wmb && !error) begin
                check("stop_after_count", 32'(strobes), 32'(v.exp_strobes));
                check("stop_after_busy_clear", 32'(prev_busy), 32'd0);
            end

            if (!rst_done && v.rst_at >= 0 && strobes == v.rst_at && !w_byte) begin
                rst = 1'b1;
                #1;
                check_all_zero("mid_reset");
                spi_busy = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                rst_done = 1'b1;
                strobes = 0;
                n_rst_spi = 0;
                busy_cnt = 0;
                prev_wmb = 1'b0;
                prev_busy = 1'b0;
                hold_chk = 1'b0;
                first_after_rise = 1'b0;
                csum = '0;
                continue;
            end

            if (err_state == 1) begin
                spi_err = 1'b1;
                err_state = 2;
            end
            if (err_state == 0 && v.err_at >= 0 && w_byte && strobes == v.err_at) err_state = 1;

            if (w_byte) busy_cnt = (v.byte_busy < 0) ? int'($urandom_range(0, 4)) : v.byte_busy;
            else if (rst_spi) busy_cnt = 2;
            else if (w_multi_block && !prev_wmb) busy_cnt = v.start_busy;
            else if (!w_multi_block && prev_wmb) busy_cnt = 2;
            spi_busy = (busy_cnt != 0);
            if (busy_cnt != 0) busy_cnt--;
            prev_busy = spi_busy;
            prev_wmb = w_multi_block;

            if (end_signal || error) begin
                post++;
                if (post > 20) begin
                    finished = 1'b1;
                    break;
                end
            end
        end

        check("finished_in_budget", 32'(finished), 32'd1);
        check("final_strobes", 32'(strobes), 32'(v.exp_strobes));
        check("final_bytes_written", bytes_written, 32'(v.exp_strobes));
        check("final_end_signal", 32'(end_signal), 32'(v.exp_end));
        check("final_error", 32'(error), 32'(v.exp_err));
        check("rst_spi_pulse_cycles", 32'(n_rst_spi), 32'd1);
        check("final_checksum", 32'(checksum), 32'(csum));
        check("final_w_multi_block", 32'(w_multi_block), 32'd0);
        check("final_block_addr", block_addr, 32'(BLK));
    endtask

    initial begin
        vecs[0] = '{3, 2, -1, -1, N_BYTES, 1'b1, 1'b0};
        vecs[1] = '{-1, 1, -1, -1, N_BYTES, 1'b1, 1'b0};
        vecs[2] = '{0, 50, -1, -1, N_BYTES, 1'b1, 1'b0};
        vecs[3] = '{2, 2, 100, -1, 100, 1'b0, 1'b1};
        vecs[4] = '{3, 3, -1, 37, N_BYTES, 1'b1, 1'b0};
        vecs[5] = '{-1, 5, 1, -1, 1, 1'b0, 1'b1};

        build_stream();
        rst = 1'b1;
        spi_busy = 1'b0;
        spi_err = 1'b0;
        #1;
        check_all_zero("reset");

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        check("first_byte", 32'(got_b0), 32'h0000_00E1);
        check("second_byte", 32'(got_b1), 32'h0000_00C3);
`ifdef TASK_WRITE_CHECKSUM_EN
        check("checksum_two_bytes", 32'(got_csum2), 32'h0000_01A4);
`else
        check("checksum_two_bytes", 32'(got_csum2), 32'h0000_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
